// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and small decode helpers used by the top level.
package md_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CALC  = 2'b01,
        ST_FIXUP = 2'b10,
        ST_DONE  = 2'b11
    } md_state_e;

    function automatic logic is_div(input md_op_e op);
        return op[2];
    endfunction

    function automatic logic is_rem(input md_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic op1_signed(input md_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op2_signed(input md_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on magnitudes: shift-add for multiply,
// restoring shift-subtract for divide. {hi, lo} is the shared working pair.
module muldiv_step #(
    parameter int W = 32
) (
    input  logic         div_i,
    input  logic [W-1:0] hi_i,
    input  logic [W-1:0] lo_i,
    input  logic [W-1:0] opb_i,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o
);

    logic [W-1:0] addend;
    logic [W:0]   sum;
    logic [W:0]   shifted;
    logic [W-1:0] diff;
    logic         ge;

    always_comb begin
        addend  = lo_i[0] ? opb_i : '0;
        sum     = {1'b0, hi_i} + {1'b0, addend};
        shifted = {hi_i, lo_i[W-1]};
        // When the trial subtract succeeds the difference is below the
        // divisor, so W bits hold it without loss.
        diff    = shifted[W-1:0] - opb_i;
        ge      = shifted >= {1'b0, opb_i};
        if (div_i) begin
            hi_o = ge ? diff : shifted[W-1:0];
            lo_o = {lo_i[W-2:0], ge};
        end else begin
            hi_o = sum[W:1];
            lo_o = {sum[0], lo_i[W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit (RISC-V M semantics). Magnitudes are
// iterated for DATA_WIDTH cycles, signs are applied in a single fixup cycle.
module muldiv_unit
    import md_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Start,
    input  logic [2:0]            MDctrl,
    input  logic [DATA_WIDTH-1:0] MDop1,
    input  logic [DATA_WIDTH-1:0] MDop2,
    input  logic                  Flush,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] MDout
);

    localparam int W = DATA_WIDTH;
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    md_state_e      state_q, state_d;
    md_op_e         op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic [W-1:0]   opb_q, opb_d;
    logic           qneg_q, qneg_d;
    logic           rneg_q, rneg_d;
    logic [W-1:0]   mdout_q, mdout_d;

    md_op_e         op_in;
    logic           neg1, neg2;
    logic [W-1:0]   mag1, mag2;
    logic           div_zero, div_ovf;
    logic [W-1:0]   fast_res;

    logic [W-1:0]   step_hi, step_lo;
    logic [2*W-1:0] prod, prod_fix;
    logic [W-1:0]   quo_fix, rem_fix;
    logic [W-1:0]   fix_res;

    muldiv_step #(.W(W)) u_step (
        .div_i (is_div(op_q)),
        .hi_i  (hi_q),
        .lo_i  (lo_q),
        .opb_i (opb_q),
        .hi_o  (step_hi),
        .lo_o  (step_lo)
    );

    // Request decode: operand magnitudes and the single-cycle special cases.
    always_comb begin
        op_in    = md_op_e'(MDctrl);
        neg1     = op1_signed(op_in) & MDop1[W-1];
        neg2     = op2_signed(op_in) & MDop2[W-1];
        mag1     = neg1 ? -MDop1 : MDop1;
        mag2     = neg2 ? -MDop2 : MDop2;
        div_zero = is_div(op_in) && (MDop2 == '0);
        div_ovf  = is_div(op_in) && op2_signed(op_in) &&
                   (MDop1 == MIN_NEG) && (MDop2 == '1);
        if (is_rem(op_in)) begin
            fast_res = div_zero ? MDop1 : '0;
        end else begin
            fast_res = div_zero ? '1 : MDop1;
        end
    end

    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = qneg_q ? -prod : prod;
        quo_fix  = qneg_q ? -lo_q : lo_q;
        rem_fix  = rneg_q ? -hi_q : hi_q;
        case (op_q)
            OP_MUL:                        fix_res = prod_fix[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod_fix[2*W-1:W];
            OP_DIV, OP_DIVU:               fix_res = quo_fix;
            default:                       fix_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opb_d   = opb_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        mdout_d = mdout_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Flush) begin
                    state_d = ST_IDLE;
                end else if (Start) begin
                    op_d   = op_in;
                    qneg_d = neg1 ^ neg2;
                    rneg_d = neg1;
                    if (div_zero || div_ovf) begin
                        state_d = ST_DONE;
                        mdout_d = fast_res;
                    end else begin
                        state_d = ST_CALC;
                        cnt_d   = CNT_W'(W);
                        hi_d    = '0;
                        // Divide iterates the dividend through lo; multiply
                        // shifts the multiplier out of lo.
                        lo_d    = is_div(op_in) ? mag1 : mag2;
                        opb_d   = is_div(op_in) ? mag2 : mag1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (Flush) begin
                    state_d = ST_IDLE;
                end else begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_FIXUP;
                    end
                end
            end
            ST_FIXUP: begin
                if (Flush) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                    mdout_d = fix_res;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MUL;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            mdout_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            mdout_q <= mdout_d;
        end
    end

    assign Busy  = (state_q == ST_CALC) || (state_q == ST_FIXUP);
    assign Done  = (state_q == ST_DONE);
    assign MDout = mdout_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: a 32-bit and an 8-bit instance, directed corner
// cases plus random operations checked against an arithmetic reference model.
module tb_muldiv_unit;

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    // Clock and reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        start, flush, busy, done;
    logic [2:0]  ctrl;
    logic [31:0] op1, op2, mdout;

    logic        start8, flush8, busy8, done8;
    logic [2:0]  ctrl8;
    logic [7:0]  op1_8, op2_8, mdout8;

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .Start(start), .MDctrl(ctrl),
        .MDop1(op1), .MDop2(op2), .Flush(flush),
        .Busy(busy), .Done(done), .MDout(mdout)
    );

    muldiv_unit #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .Start(start8), .MDctrl(ctrl8),
        .MDop1(op1_8), .MDop2(op2_8), .Flush(flush8),
        .Busy(busy8), .Done(done8), .MDout(mdout8)
    );

    int total = 0;
    int bad = 0;

    logic [31:0] exp_q[$];
    int          lat_q[$];
    int          iss_q[$];
    logic [31:0] exp8_q[$];
    int          lat8_q[$];
    int          iss8_q[$];
    logic [31:0] last_res = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: extend operands by signedness and use plain
    // wide arithmetic; SV division truncates toward zero like the ISA.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a_in,
                                          input logic [31:0] b_in, input int w);
        logic [127:0]        mask, res;
        logic signed [127:0] sa, sb, p;
        logic [31:0]         a, b;
        logic                s1, s2;
        mask = (128'd1 << w) - 128'd1;
        a = a_in & mask[31:0];
        b = b_in & mask[31:0];
        s1 = (op == MUL) || (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
        s2 = (op == MUL) || (op == MULH) || (op == DIV) || (op == REM);
        sa = $signed({96'd0, a});
        sb = $signed({96'd0, b});
        if (s1 && a[w-1]) sa = sa - (128'sd1 <<< w);
        if (s2 && b[w-1]) sb = sb - (128'sd1 <<< w);
        if (!op[2]) begin
            p = sa * sb;
            res = (op == MUL) ? 128'(p) : 128'(p >>> w);
        end else if (b == '0) begin
            res = op[1] ? {96'd0, a} : mask;
        end else if (s1 && sa == -(128'sd1 <<< (w - 1)) && sb == -128'sd1) begin
            res = op[1] ? 128'd0 : {96'd0, a};
        end else begin
            res = op[1] ? 128'(sa % sb) : 128'(sa / sb);
        end
        res = res & mask;
        return res[31:0];
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input int w);
        logic [31:0] mask;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        if (op[2] && ((b & mask) == 0)) return 1;
        if (op[2] && !op[0] && (a & mask) == (32'd1 << (w - 1)) && (b & mask) == mask) return 1;
        return w + 2;
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] mask, v;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = '1;
            2: v = 32'd1 << (w - 1);
            3: v = 32'($urandom_range(1, 9));
            4: v = -32'($urandom_range(1, 9));
            default: v = $urandom;
        endcase
        return v & mask;
    endfunction

    // Monitors: pop and compare whenever a Done pulse is presented.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done32: got Done=1 MDout=%h want no Done", mdout);
            end else begin
                logic [31:0] e;
                int l, s;
                e = exp_q.pop_front();
                l = lat_q.pop_front();
                s = iss_q.pop_front();
                chk("result32", mdout, e);
                chk("latency32", 32'(cyc - s), 32'(l));
                last_res = e;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done8) begin
            if (exp8_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done8: got Done=1 MDout=%h want no Done", mdout8);
            end else begin
                logic [31:0] e;
                int l, s;
                e = exp8_q.pop_front();
                l = lat8_q.pop_front();
                s = iss8_q.pop_front();
                chk("result8", {24'd0, mdout8}, e);
                chk("latency8", 32'(cyc - s), 32'(l));
            end
        end
    end

    // Driver: waits for Busy=0, presents Start for one edge.
    task automatic issue(input bit w8, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit track,
                         input logic [31:0] e, input int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while ((w8 ? busy8 : busy) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            total++;
            bad++;
            $display("FAIL busy_timeout: got Busy=1 after %0d cycles want 0", guard);
        end
        if (w8) begin
            ctrl8 = op; op1_8 = a[7:0]; op2_8 = b[7:0]; start8 = 1'b1;
            if (track) begin exp8_q.push_back(e); lat8_q.push_back(lat); iss8_q.push_back(cyc); end
        end else begin
            ctrl = op; op1 = a; op2 = b; start = 1'b1;
            if (track) begin exp_q.push_back(e); lat_q.push_back(lat); iss_q.push_back(cyc); end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        start8 = 1'b0;
    endtask

    task automatic issue_rand(input bit w8, input int n);
        int w;
        w = w8 ? 8 : 32;
        for (int i = 0; i < n; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a = pick(w);
            b = pick(w);
            issue(w8, op, a, b, 1'b1, model(op, a, b, w), exp_lat(op, a, b, w));
        end
    endtask

    task automatic wait_quiet();
        int g;
        g = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || exp8_q.size() != 0 || busy || busy8) && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 1000) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d/%0d pending want 0/0", exp_q.size(), exp8_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish by %0t want finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        start = 0; flush = 0; ctrl = 0; op1 = 0; op2 = 0;
        start8 = 0; flush8 = 0; ctrl8 = 0; op1_8 = 0; op2_8 = 0;

        #12;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_mdout", mdout, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner cases
        issue(0, MUL, 32'hFFFF_FFFD, 32'd7, 1, 32'hFFFF_FFEB, 34);
        repeat (3) @(negedge clk);
        ctrl = MULHU; op1 = 32'd123; op2 = 32'd456; start = 1'b1;   // ignored while busy
        @(posedge clk);
        #1 start = 1'b0;
        issue(0, MULH,   32'hFFFF_FFFD, 32'd7,         1, 32'hFFFF_FFFF, 34);
        issue(0, MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 34);
        issue(0, MULHSU, 32'hFFFF_FFFF, 32'd2,         1, 32'hFFFF_FFFF, 34);
        issue(0, DIV,    32'hFFFF_FFF9, 32'd2,         1, 32'hFFFF_FFFD, 34);
        issue(0, REM,    32'hFFFF_FFF9, 32'd2,         1, 32'hFFFF_FFFF, 34);
        issue(0, DIVU,   32'd7,         32'd0,         1, 32'hFFFF_FFFF, 1);
        issue(0, DIV,    32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1);
        issue(0, REM,    32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000, 1);
        issue(0, REMU,   32'd9,         32'd0,         1, 32'd9,         1);

        // Flush mid-operation, with a Start in the same cycle discarded
        wait_quiet();
        issue(0, DIVU, 32'd100_000, 32'd7, 0, '0, 0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        ctrl = MUL; op1 = 32'd5; op2 = 32'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_mdout", mdout, last_res);
        issue(0, DIVU, 32'd100_000, 32'd7, 1, 32'd14285, 34);

        // Reset pulse mid-calculation
        wait_quiet();
        issue(0, MUL, 32'd1234, 32'd5678, 0, '0, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_mdout", mdout, 32'd0);
        last_res = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(0, MUL, 32'd1234, 32'd5678, 1, 32'd7006652, 34);

        issue_rand(0, 60);

        // Narrow instance
        issue(1, MULHU, 32'hFF, 32'hFF, 1, 32'hFE, 10);
        issue(1, DIV,   32'h80, 32'hFF, 1, 32'h80, 1);
        issue_rand(1, 30);

        wait_quiet();
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
